crypto_block_responder: RTL and testbench

Responder end of the crypto block interface. Sits on the crypto-core side of the top level's block interface and drives the signals the register bank reads back: it accepts `crypto_start` with key and text, runs a deterministic iterative test transform over a programmable number of rounds, and returns the result with `crypto_ready`, `crypto_done` and `crypto_idle`. It is the team's reference/loopback core for validating the block interface, capture timing and the `~crypto_idle` trigger path without a real cipher.

---
 rtl/crypto_block_pkg.sv | 14 +
 rtl/crypto_block_round.sv | 25 ++
 rtl/crypto_block_responder.sv | 116 +++++++++++
 tb/tb_crypto_block_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_block_pkg.sv
// Shared types and limits for the crypto block responder (loopback test core).
package crypto_block_pkg;

    localparam int CRYPTO_BLOCK_WIDTH_DEFAULT = 128;
    localparam int CRYPTO_BLOCK_ROUNDS_MAX    = 255;
    localparam int CRYPTO_BLOCK_CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } crypto_state_e;

endpackage

// File: rtl/crypto_block_round.sv
// One round of the test transform: k' = rotl(k,8), s' = rotl(s,1) ^ k' ^ zext(r).
module crypto_block_round
    import crypto_block_pkg::*;
#(
    parameter int WIDTH = CRYPTO_BLOCK_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0]              s,
    input  logic [WIDTH-1:0]              k,
    input  logic [CRYPTO_BLOCK_CNT_W-1:0] r,
    output logic [WIDTH-1:0]              s_next,
    output logic [WIDTH-1:0]              k_next
);

    localparam int NBYTES = WIDTH / 8;

    // Rotating left by one byte moves every byte up one lane, top byte wraps to lane 0.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_key_rot
        assign k_next[gi*8 +: 8] = k[((gi + NBYTES - 1) % NBYTES)*8 +: 8];
    end

    assign s_next = {s[WIDTH-2:0], s[WIDTH-1]}
                  ^ k_next
                  ^ {{(WIDTH-CRYPTO_BLOCK_CNT_W){1'b0}}, r};

endmodule

// File: rtl/crypto_block_responder.sv
// Reference/loopback crypto core for the block interface: iterative test transform.
// Optional feature: BLOCK_RESP_RESTART_EN lets a start during RUN restart the operation.
module crypto_block_responder
    import crypto_block_pkg::*;
#(
    parameter int WIDTH  = CRYPTO_BLOCK_WIDTH_DEFAULT,
    parameter int ROUNDS = 10
) (
    input  logic             crypto_clk,
    input  logic             crypto_rstn,
    input  logic [WIDTH-1:0] crypto_textout,
    input  logic [WIDTH-1:0] crypto_keyout,
    input  logic             crypto_start,
    output logic [WIDTH-1:0] crypto_cipherin,
    output logic             crypto_ready,
    output logic             crypto_done,
    output logic             crypto_idle
);

    if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_bad_width
        $error("crypto_block_responder: WIDTH must be a multiple of 8 and >= 16");
    end
    if (ROUNDS < 1 || ROUNDS > CRYPTO_BLOCK_ROUNDS_MAX) begin : g_bad_rounds
        $error("crypto_block_responder: ROUNDS must be in 1..255");
    end

`ifdef BLOCK_RESP_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    localparam logic [CRYPTO_BLOCK_CNT_W-1:0] LAST_ROUND = CRYPTO_BLOCK_CNT_W'(ROUNDS);

    crypto_state_e                 state_reg;
    crypto_state_e                 state_next;
    logic [WIDTH-1:0]              s_reg;
    logic [WIDTH-1:0]              k_reg;
    logic [CRYPTO_BLOCK_CNT_W-1:0] r_reg;
    logic [WIDTH-1:0]              cipher_reg;
    logic [WIDTH-1:0]              s_next;
    logic [WIDTH-1:0]              k_next;
    logic                          load;
    logic                          advance;
    logic                          finish;

    crypto_block_round #(
        .WIDTH (WIDTH)
    ) u_round (
        .s      (s_reg),
        .k      (k_reg),
        .r      (r_reg),
        .s_next (s_next),
        .k_next (k_next)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        unique case (state_reg)
            IDLE, DONE: begin
                if (crypto_start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (RESTART_EN && crypto_start) begin
                    load = 1'b1;
                end else begin
                    advance = 1'b1;
                    if (r_reg == LAST_ROUND) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge crypto_clk) begin
        if (!crypto_rstn) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            k_reg      <= '0;
            r_reg      <= '0;
            cipher_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                s_reg <= crypto_textout ^ crypto_keyout;
                k_reg <= crypto_keyout;
                r_reg <= CRYPTO_BLOCK_CNT_W'(1);
            end else if (advance) begin
                s_reg <= s_next;
                k_reg <= k_next;
                r_reg <= r_reg + 1'b1;
            end
            // The final round's result goes straight to the output register.
            if (finish) begin
                cipher_reg <= s_next;
            end
        end
    end

    assign crypto_cipherin = cipher_reg;
    assign crypto_ready    = (state_reg != RUN) || RESTART_EN;
    assign crypto_idle     = (state_reg != RUN);
    assign crypto_done     = (state_reg == DONE);

endmodule

// File: tb/tb_crypto_block_responder.sv
// Bench for crypto_block_responder: four instances (ROUNDS 1, 2, 10, 255) share stimulus.
module tb_crypto_block_responder;

    localparam int W  = 128;
    localparam int NI = 4;
    localparam int RND [NI] = '{1, 2, 10, 255};
`ifdef BLOCK_RESP_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic         crypto_clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [W-1:0] text;
    logic [W-1:0] key;

    logic [W-1:0] cipher_w [NI];
    logic         ready_w  [NI];
    logic         done_w   [NI];
    logic         idle_w   [NI];

    int checks   = 0;
    int failures = 0;

    always #5 crypto_clk = ~crypto_clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        crypto_block_responder #(
            .WIDTH  (W),
            .ROUNDS (gi == 0 ? 1 : gi == 1 ? 2 : gi == 2 ? 10 : 255)
        ) u_dut (
            .crypto_clk      (crypto_clk),
            .crypto_rstn     (rstn),
            .crypto_textout  (text),
            .crypto_keyout   (key),
            .crypto_start    (start),
            .crypto_cipherin (cipher_w[gi]),
            .crypto_ready    (ready_w[gi]),
            .crypto_done     (done_w[gi]),
            .crypto_idle     (idle_w[gi])
        );
    end

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
        return (x << n) | (x >> (W - n));
    endfunction

    // Whole-operation result computed directly from the transform definition.
    function automatic logic [W-1:0] encrypt(input logic [W-1:0] t, input logic [W-1:0] kk,
                                             input int rounds);
        logic [W-1:0] s;
        logic [W-1:0] k;
        s = t ^ kk;
        k = kk;
        for (int r = 1; r <= rounds; r++) begin
            k = rotl(k, 8);
            s = rotl(s, 1) ^ k ^ W'(r % 256);
        end
        return s;
    endfunction

    task automatic check(input string name, input int idx, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Transaction-level model: an accepted start schedules its result ROUNDS edges later.
    logic         mvalid = 1'b0;
    logic         m_run    [NI];
    int           m_left   [NI];
    logic         m_done   [NI];
    logic [W-1:0] m_cipher [NI];
    logic [W-1:0] m_pend   [NI];

    always @(posedge crypto_clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rstn) begin
                m_run[i]    <= 1'b0;
                m_left[i]   <= 0;
                m_done[i]   <= 1'b0;
                m_cipher[i] <= '0;
            end else if (m_run[i] && !(RESTART && start)) begin
                m_done[i] <= (m_left[i] == 1);
                if (m_left[i] == 1) begin
                    m_run[i]    <= 1'b0;
                    m_cipher[i] <= m_pend[i];
                end
                m_left[i] <= m_left[i] - 1;
            end else begin
                m_done[i] <= 1'b0;
                if (start) begin
                    m_run[i]  <= 1'b1;
                    m_left[i] <= RND[i];
                    m_pend[i] <= encrypt(text, key, RND[i]);
                end
            end
        end
        mvalid <= 1'b1;
    end

    always @(posedge crypto_clk) begin
        #1;
        if (mvalid) begin
            for (int i = 0; i < NI; i++) begin
                check("cyc_ready",  i, ready_w[i],  !m_run[i] || RESTART);
                check("cyc_idle",   i, idle_w[i],   !m_run[i]);
                check("cyc_done",   i, done_w[i],   m_done[i]);
                check("cyc_cipher", i, cipher_w[i], m_cipher[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge crypto_clk);
    endtask

    task automatic wait_quiet(input int idx);
        int n;
        n = 0;
        while (!(idle_w[idx] && !done_w[idx]) && n < 400) begin
            step(1);
            n++;
        end
        if (n >= 400) check("wait_quiet_timeout", idx, 1'b0, 1'b1);
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int idle_low;
        int dones;
        rstn  = 1'b0;
        start = 1'b0;
        text  = '0;
        key   = '0;
        step(2);

        check("model_r1_zero", 0, encrypt('0, '0, 1), 128'h1);
        check("model_r1_key1", 0, encrypt('0, 128'h1, 1), 128'h103);
        check("model_r2_zero", 1, encrypt('0, '0, 2), '0);
        check("rst_ready",  2, ready_w[2], 1'b1);
        check("rst_idle",   2, idle_w[2], 1'b1);
        check("rst_done",   2, done_w[2], 1'b0);
        check("rst_cipher", 3, cipher_w[3], '0);

        rstn = 1'b1;
        step(1);

        // ROUNDS=1, zero key/text: done two cycles after the start edge, one idle-low cycle
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("a_idle_low", 0, idle_w[0], 1'b0);
        step(1);
        check("a_done",   0, done_w[0], 1'b1);
        check("a_cipher", 0, cipher_w[0], 128'h1);
        step(1);
        check("a_idle_back", 0, idle_w[0], 1'b1);
        check("a_done_gone", 0, done_w[0], 1'b0);
        $display("txn A: rounds=1 key=0 text=0 cipher=%h", cipher_w[0]);
        step(3);

        // ROUNDS=1, key=1
        key   = 128'h1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("b_done",   0, done_w[0], 1'b1);
        check("b_cipher", 0, cipher_w[0], 128'h103);
        $display("txn B: rounds=1 key=1 text=0 cipher=%h", cipher_w[0]);
        step(3);

        // ROUNDS=2, zero key/text; text changes after the accept edge
        key   = '0;
        text  = '0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        text  = '1;
        step(2);
        check("c_done",   1, done_w[1], 1'b1);
        check("c_cipher", 1, cipher_w[1], '0);
        $display("txn C: rounds=2 key=0 text=0 (then all-ones) cipher=%h", cipher_w[1]);

        // ROUNDS=10: back-to-back start in the done cycle, then starts during RUN
        wait_quiet(2);
        text  = rand_word();
        key   = rand_word();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        check("d_done", 2, done_w[2], 1'b1);
        text  = rand_word();
        key   = rand_word();
        start = 1'b1;
        step(1);
        check("d_b2b_idle", 2, idle_w[2], 1'b0);
        key = rand_word();
        step(1);
        check("d_run_ready", 2, ready_w[2], RESTART);
        step(2);
        start    = 1'b0;
        idle_low = 0;
        dones    = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (!idle_w[2]) idle_low++;
            if (done_w[2])  dones++;
        end
        check("d_idle_low_tail", 2, W'(idle_low), RESTART ? W'(9) : W'(6));
        check("d_done_pulses",   2, W'(dones), W'(1));
        $display("txn D: rounds=10 b2b+run starts idle_low_tail=%0d dones=%0d cipher=%h",
                 idle_low, dones, cipher_w[2]);

        // ROUNDS=10: reset asserted at round 5 aborts the operation
        wait_quiet(2);
        text  = rand_word();
        key   = rand_word();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        rstn = 1'b0;
        step(1);
        check("e_idle",   2, idle_w[2], 1'b1);
        check("e_ready",  2, ready_w[2], 1'b1);
        check("e_done",   2, done_w[2], 1'b0);
        check("e_cipher", 2, cipher_w[2], '0);
        rstn  = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            if (done_w[2]) dones++;
        end
        check("e_no_done", 2, W'(dones), W'(0));
        $display("txn E: rounds=10 reset at round 5 dones_after=%0d", dones);

        // Random key/text with frequent starts; the model checks every cycle
        for (int c = 0; c < 30000; c++) begin
            start = ($urandom_range(0, 7) != 0);
            text  = rand_word();
            key   = rand_word();
            step(1);
        end
        start = 1'b0;
        step(300);
        $display("txn R: random phase complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
